instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue_if.sv | 34 +++
 rtl/instr_fetch_queue.sv | 88 ++++++++
 tb/tb_instr_fetch_queue.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if
//   Groups the byte-in and instruction-out handshakes of the fetch queue,
//   together with its flush control and status flags.
//   master : the surrounding system (byte source, core, flush control)
//   slave  : the queue itself
// Signals:
//   byte_valid/byte_data/byte_ready  byte stream in (low byte first)
//   flush                            synchronous discard of queued data
//   inst_valid/inst_data/inst_ready  16-bit instruction out to the core
//   level                            complete instructions held
//   half_pending                     low byte held, waiting for high byte
//   err_overflow                     sticky: byte offered while not ready
interface instr_fetch_queue_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        flush;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic        inst_ready;
  logic [3:0]  level;
  logic        half_pending;
  logic        err_overflow;

  modport master (
    output byte_valid, byte_data, flush, inst_ready,
    input  byte_ready, inst_valid, inst_data, level, half_pending, err_overflow
  );

  modport slave (
    input  byte_valid, byte_data, flush, inst_ready,
    output byte_ready, inst_valid, inst_data, level, half_pending, err_overflow
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Assembles a byte stream into 16-bit instructions (first byte is the low
//   half) and queues them in a DEPTH-entry FIFO for the core.
// Ports:
//   clk  - single clock, rising edge
//   rst  - asynchronous, active-high reset; clears all state and storage
//   bus  - instr_fetch_queue_if.slave (byte in, instruction out, flush, status)
// Parameters:
//   DEPTH - FIFO depth in instructions, power of two, 2..8
module instr_fetch_queue #(
  parameter int DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_queue_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [3:0]    level_q;
  logic          half_q;
  logic [7:0]    low_q;
  logic          err_q;

  logic byte_ready_w;
  logic accept;
  logic push;
  logic pop;

  // Only a completing (high) byte needs a free slot, so a low byte is still
  // accepted while full. Depends on registered state only, so a pop at full
  // frees the slot for the byte side one cycle later.
  assign byte_ready_w = !(half_q && (level_q == 4'(DEPTH)));
  assign accept       = bus.byte_valid && byte_ready_w;
  assign push         = accept && half_q;
  assign pop          = (level_q != 4'd0) && bus.inst_ready;

  assign bus.byte_ready   = byte_ready_w;
  assign bus.inst_valid   = (level_q != 4'd0);
  assign bus.inst_data    = mem[rd_ptr];
  assign bus.level        = level_q;
  assign bus.half_pending = half_q;
  assign bus.err_overflow = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
      half_q  <= 1'b0;
      low_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush) begin
      // storage and low_q are left as-is; pointers and flags make them dead
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level_q <= '0;
      half_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (bus.byte_valid && !byte_ready_w) err_q <= 1'b1;

      if (accept) begin
        if (half_q) begin
          mem[wr_ptr] <= {bus.byte_data, low_q};
          wr_ptr      <= wr_ptr + AW'(1);
          half_q      <= 1'b0;
        end else begin
          low_q  <= bus.byte_data;
          half_q <= 1'b1;
        end
      end

      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   level_q <= level_q + 4'd1;
        2'b01:   level_q <= level_q - 4'd1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  instr_fetch_queue_if bus ();

  instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of whole instructions plus the pending low byte.
  logic [15:0] m_q[$];
  logic        m_half = 1'b0;
  logic [7:0]  m_low  = 8'h00;
  logic        m_err  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_half = 1'b0;
      m_low  = 8'h00;
      m_err  = 1'b0;
    end else if (bus.flush) begin
      m_q.delete();
      m_half = 1'b0;
      m_err  = 1'b0;
    end else begin
      automatic bit rdy   = !(m_half && m_q.size() == DEPTH);
      automatic bit do_pp = (m_q.size() != 0) && bus.inst_ready;
      automatic bit acc   = bus.byte_valid && rdy;
      if (bus.byte_valid && !rdy) m_err = 1'b1;
      if (do_pp) void'(m_q.pop_front());
      if (acc) begin
        if (m_half) begin
          m_q.push_back({bus.byte_data, m_low});
          m_half = 1'b0;
        end else begin
          m_low  = bus.byte_data;
          m_half = 1'b1;
        end
      end
    end
  end

  // Compare process: every negedge, DUT status and head against the model.
  bit check_en = 1'b0;
  always @(negedge clk) begin
    if (check_en) begin
      chk("byte_ready",   16'(bus.byte_ready),   16'(!(m_half && m_q.size() == DEPTH)));
      chk("inst_valid",   16'(bus.inst_valid),   16'(m_q.size() != 0));
      chk("level",        16'(bus.level),        16'(m_q.size()));
      chk("half_pending", 16'(bus.half_pending), 16'(m_half));
      chk("err_overflow", 16'(bus.err_overflow), 16'(m_err));
      if (m_q.size() != 0) chk("inst_data", bus.inst_data, m_q[0]);
    end
  end

  // Records instructions actually handed to the core during the stream test.
  bit          rec_en = 1'b0;
  logic [15:0] rec[$];
  always @(posedge clk) begin
    if (rec_en && !rst && !bus.flush && bus.inst_valid && bus.inst_ready)
      rec.push_back(bus.inst_data);
  end

  task automatic cyc(input bit bv, input logic [7:0] bd, input bit fl, input bit ir);
    bus.byte_valid = bv;
    bus.byte_data  = bd;
    bus.flush      = fl;
    bus.inst_ready = ir;
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b1;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    bus.flush      = 1'b0;
    bus.inst_ready = 1'b0;
    @(negedge clk);

    chk("rst_level",      16'(bus.level),        16'd0);
    chk("rst_half",       16'(bus.half_pending), 16'd0);
    chk("rst_err",        16'(bus.err_overflow), 16'd0);
    chk("rst_inst_valid", 16'(bus.inst_valid),   16'd0);
    chk("rst_byte_ready", 16'(bus.byte_ready),   16'd1);
    chk("rst_inst_data",  bus.inst_data,         16'h0000);
    rst      = 1'b0;
    check_en = 1'b1;

    // two bytes form one instruction, visible the cycle after the high byte
    cyc(1, 8'h2D, 0, 0);
    cyc(1, 8'h6C, 0, 0);
    chk("pair_valid", 16'(bus.inst_valid),   16'd1);
    chk("pair_data",  bus.inst_data,         16'h6C2D);
    chk("pair_level", 16'(bus.level),        16'd1);
    chk("pair_half",  16'(bus.half_pending), 16'd0);
    cyc(0, 8'h00, 1, 0);

    // fill: 9 bytes -> 4 instructions + pending low byte
    for (int i = 1; i <= 9; i++) cyc(1, 8'(8'h10 + i), 0, 0);
    chk("full_level", 16'(bus.level),        16'd4);
    chk("full_half",  16'(bus.half_pending), 16'd1);
    chk("full_ready", 16'(bus.byte_ready),   16'd0);
    cyc(1, 8'h1A, 0, 0);
    chk("full_err",   16'(bus.err_overflow), 16'd1);
    chk("full_level2", 16'(bus.level),       16'd4);
    cyc(1, 8'h1A, 0, 1);
    chk("pop_level",  16'(bus.level),        16'd3);
    chk("pop_ready",  16'(bus.byte_ready),   16'd1);
    chk("pop_head",   bus.inst_data,         16'h1413);
    cyc(1, 8'h1A, 0, 0);
    chk("refill_level", 16'(bus.level),      16'd4);
    chk("refill_half",  16'(bus.half_pending), 16'd0);

    // flush wins over a concurrent byte and pop
    cyc(0, 8'h00, 0, 1);
    cyc(1, 8'h55, 0, 0);
    chk("pre_flush_level", 16'(bus.level),        16'd3);
    chk("pre_flush_half",  16'(bus.half_pending), 16'd1);
    chk("pre_flush_err",   16'(bus.err_overflow), 16'd1);
    cyc(1, 8'h77, 1, 1);
    chk("flush_level", 16'(bus.level),        16'd0);
    chk("flush_valid", 16'(bus.inst_valid),   16'd0);
    chk("flush_half",  16'(bus.half_pending), 16'd0);
    chk("flush_err",   16'(bus.err_overflow), 16'd0);
    cyc(1, 8'h34, 0, 0);
    cyc(1, 8'h12, 0, 0);
    chk("post_flush_data", bus.inst_data, 16'h1234);

    // simultaneous push and pop at level 2
    cyc(1, 8'h78, 0, 0);
    cyc(1, 8'h56, 0, 0);
    cyc(1, 8'h9A, 0, 0);
    chk("pp_level_before", 16'(bus.level), 16'd2);
    cyc(1, 8'hBC, 0, 1);
    chk("pp_level", 16'(bus.level), 16'd2);
    chk("pp_head",  bus.inst_data,  16'h5678);
    cyc(0, 8'h00, 1, 0);

    // back-to-back stream across pointer wrap
    rec_en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 8'(i), 0, 1);
      cyc(1, 8'h00, 0, 1);
    end
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 1);
    rec_en = 1'b0;
    chk("stream_count", 16'(rec.size()), 16'd10);
    for (int i = 0; i < rec.size() && i < 10; i++) chk("stream_order", rec[i], 16'(i + 1));
    chk("stream_err", 16'(bus.err_overflow), 16'd0);

    // randomized traffic; slow consumer first, then fast consumer
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 49) == 0,
          $urandom_range(0, 2) == 0);
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 99) == 0,
          $urandom_range(0, 3) != 0);
    cyc(0, 8'h00, 1, 0);

    // asynchronous reset between edges at level 2 with a pending low byte
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'hA0 + i), 0, 0);
    chk("prerst_level", 16'(bus.level), 16'd2);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 16'(bus.inst_valid),   16'd0);
    chk("arst_data",  bus.inst_data,         16'h0000);
    chk("arst_level", 16'(bus.level),        16'd0);
    chk("arst_half",  16'(bus.half_pending), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(1, 8'h11, 0, 0);
    cyc(1, 8'h22, 0, 0);
    chk("postrst_data",  bus.inst_data,  16'h2211);
    chk("postrst_level", 16'(bus.level), 16'd1);
    cyc(0, 8'h00, 0, 0);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
